// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and defaults for the 110101 detector frame controller.
// FSM state encoding and default beat/counter widths.
package seq_det_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating hit counter with sticky overflow; clr wins over inc, result visible next cycle.
// No backpressure: an increment at the maximum value only sets ovf.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (inc) begin
         if (count == CNT_MAX) ovf <= 1'b1;
         else                  count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serializes framed bytes MSB-first into a 110101 Moore detector and counts hits per frame.
// frame_done at N*DATA_W+2 cycles after first accept (+1 per starved cycle); s_ready depends on state only.
module seq_det_ctrl
   import seq_det_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              det_x,
   output logic              det_en,
   output logic              det_clr,
   input  logic              det_y,
   output logic              frame_done,
   output logic [CNT_W-1:0]  match_count,
   output logic              match_ovf
);

   localparam int               IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  bit_idx;
   logic              last_q;
   logic              en_q;
   logic              accept;
   logic              first_accept;

   assign s_ready = (state == IDLE) || (state == WAIT) ||
                    ((state == SHIFT) && (bit_idx == '0) && !last_q);
   assign accept       = s_valid && s_ready;
   assign first_accept = accept && (state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_idx    <= '0;
         last_q     <= 1'b0;
         det_x      <= 1'b0;
         det_en     <= 1'b0;
         det_clr    <= 1'b1;
         frame_done <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         en_q <= det_en;
         // Any accepted beat (IDLE, WAIT or last bit of a non-final beat) loads the shifter.
         if (accept) begin
            state   <= SHIFT;
            shreg   <= s_data;
            bit_idx <= IDX_TOP;
            last_q  <= s_last;
            det_x   <= s_data[DATA_W-1];
            det_en  <= 1'b1;
            det_clr <= 1'b0;
         end else begin
            case (state)
               SHIFT: begin
                  if (bit_idx != '0) begin
                     shreg   <= {shreg[DATA_W-2:0], 1'b0};
                     bit_idx <= bit_idx - IDX_W'(1);
                     det_x   <= shreg[DATA_W-2];
                  end else begin
                     state  <= last_q ? DRAIN : WAIT;
                     det_x  <= 1'b0;
                     det_en <= 1'b0;
                  end
               end
               DRAIN: begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                  det_clr    <= 1'b1;
               end
               DONE: begin
                  state      <= IDLE;
                  frame_done <= 1'b0;
               end
               IDLE, WAIT: ;
               default: begin
                  state      <= IDLE;
                  det_x      <= 1'b0;
                  det_en     <= 1'b0;
                  det_clr    <= 1'b1;
                  frame_done <= 1'b0;
               end
            endcase
         end
      end
   end

   // en_q aligns the one-cycle detector latency so a held Moore output counts once.
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (first_accept),
      .inc   (en_q && det_y),
      .count (match_count),
      .ovf   (match_ovf)
   );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench: two controllers (CNT_W 8 and 2) sharing one stream, each driving a 110101 Moore detector.
module tb_seq_det_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_last;

   logic       s_ready1, det_x1, det_en1, det_clr1, det_y1, frame_done1, match_ovf1;
   logic [7:0] match_count1;
   logic       s_ready2, det_x2, det_en2, det_clr2, det_y2, frame_done2, match_ovf2;
   logic [1:0] match_count2;
   logic [5:0] hist1, hist2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_det_ctrl #(.DATA_W(8), .CNT_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
      .s_last(s_last), .det_x(det_x1), .det_en(det_en1), .det_clr(det_clr1), .det_y(det_y1),
      .frame_done(frame_done1), .match_count(match_count1), .match_ovf(match_ovf1));

   seq_det_ctrl #(.DATA_W(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
      .s_last(s_last), .det_x(det_x2), .det_en(det_en2), .det_clr(det_clr2), .det_y(det_y2),
      .frame_done(frame_done2), .match_count(match_count2), .match_ovf(match_ovf2));

   // Moore 110101 detector: history of enabled bits, output decoded from state.
   always @(posedge clk or negedge reset) begin
      if (!reset)        hist1 <= '0;
      else if (det_clr1) hist1 <= '0;
      else if (det_en1)  hist1 <= {hist1[4:0], det_x1};
   end
   always @(posedge clk or negedge reset) begin
      if (!reset)        hist2 <= '0;
      else if (det_clr2) hist2 <= '0;
      else if (det_en2)  hist2 <= {hist2[4:0], det_x2};
   end
   assign det_y1 = (hist1 == 6'b110101);
   assign det_y2 = (hist2 == 6'b110101);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"},   s_ready1,     32'd1);
      chk({tag, "_x"},     det_x1,       32'd0);
      chk({tag, "_en"},    det_en1,      32'd0);
      chk({tag, "_clr"},   det_clr1,     32'd1);
      chk({tag, "_done"},  frame_done1,  32'd0);
      chk({tag, "_cnt"},   match_count1, 32'd0);
      chk({tag, "_ovf"},   match_ovf1,   32'd0);
      chk({tag, "_cnt2"},  match_count2, 32'd0);
   endtask

   // Streams up to three beats; j counts cycles after the first accepting edge (j=0 carries bit 7).
   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int nb, input int stall, input int abort_j,
                            output int done_j, output logic [31:0] rdy_v, output logic [31:0] en_v,
                            output logic [23:0] bits, output int nbits);
      logic [7:0] beat [3];
      int   j, bi, need;
      logic pend;
      beat[0] = b0; beat[1] = b1; beat[2] = b2;
      j = -1; bi = 0; pend = 1'b0; done_j = -1;
      rdy_v = '0; en_v = '0; bits = '0; nbits = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (j >= 0) j++;
         if (pend) begin
            if (j < 0) j = 0;
            bi++;
         end
         if (j >= 0 && j < 32) begin
            rdy_v[j] = s_ready1;
            en_v[j]  = det_en1;
         end
         if (j >= 0 && det_en1) begin
            bits = {bits[22:0], det_x1};
            nbits++;
         end
         if (frame_done1) begin
            done_j  = j;
            s_valid = 1'b0;
            break;
         end
         if (abort_j >= 0 && j == abort_j) begin
            reset   = 1'b0;
            s_valid = 1'b0;
            break;
         end
         need = (bi == 0) ? -1 : 8 * bi - 1 + ((bi == 1) ? stall : 0);
         if (bi < nb && j >= need) begin
            s_valid = 1'b1;
            s_data  = beat[bi];
            s_last  = (bi == nb - 1);
         end else begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom_range(0, 1));
         end
         pend = s_valid && s_ready1;
      end
   endtask

   int          done_j, nbits, cnt;
   logic [31:0] rdy_v, en_v;
   logic [23:0] bits;

   initial begin
      reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      reset = 1'b1;

      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (det_clr1 && s_ready1 && !det_en1 && !frame_done1 && match_count1 == 8'd0) cnt++;
      end
      chk("idle20", cnt, 32'd20);

      // Single beat 0xD4 carrying one match
      run_frame(8'hD4, 8'h00, 8'h00, 1, 0, -1, done_j, rdy_v, en_v, bits, nbits);
      chk("d4_cycle", done_j + 1, 32'd10);
      chk("d4_bits",  {bits[7:0], 8'(nbits)}, {8'hD4, 8'd8});
      chk("d4_en",    en_v, 32'h0000_00FF);
      chk("d4_cnt",   match_count1, 32'd1);
      chk("d4_ovf",   match_ovf1, 32'd0);
      @(negedge clk);
      chk("d4_pulse", frame_done1, 32'd0);
      chk("d4_hold",  match_count1, 32'd1);

      // Two beats back-to-back, overlapping matches across the beat boundary
      run_frame(8'hD6, 8'hA0, 8'h00, 2, 0, -1, done_j, rdy_v, en_v, bits, nbits);
      chk("b2b_cycle", done_j + 1, 32'd18);
      chk("b2b_rdy",   rdy_v, 32'h0000_0080);
      chk("b2b_en",    en_v, 32'h0000_FFFF);
      chk("b2b_bits",  {bits[15:0], 8'(nbits)}, {16'hD6A0, 8'd16});
      chk("b2b_cnt",   match_count1, 32'd2);

      // Same frame starved for three cycles between beats
      run_frame(8'hD6, 8'hA0, 8'h00, 2, 3, -1, done_j, rdy_v, en_v, bits, nbits);
      chk("stall_cycle", done_j + 1, 32'd21);
      chk("stall_en",    en_v, 32'h0007_F8FF);
      chk("stall_rdy",   rdy_v, 32'h0000_0780);
      chk("stall_cnt",   match_count1, 32'd2);

      // Four matches: fits in 8 bits, saturates the 2-bit counter
      run_frame(8'hD6, 8'hB5, 8'hAD, 3, 0, -1, done_j, rdy_v, en_v, bits, nbits);
      chk("three_cycle", done_j + 1, 32'd26);
      chk("three_cnt",   match_count1, 32'd4);
      chk("three_ovf",   match_ovf1, 32'd0);
      chk("sat_cnt",     match_count2, 32'd3);
      chk("sat_ovf",     match_ovf2, 32'd1);
      @(negedge clk);
      chk("sat_hold",    {30'd0, match_ovf2, frame_done2}, 32'd2);

      // Overflow flag clears on the next frame's first accept
      run_frame(8'hD4, 8'h00, 8'h00, 1, 0, -1, done_j, rdy_v, en_v, bits, nbits);
      chk("reclr_cnt", match_count2, 32'd1);
      chk("reclr_ovf", match_ovf2, 32'd0);

      // Reset in the middle of beat 2 drops the frame silently
      run_frame(8'hD6, 8'hA0, 8'h00, 2, 0, 10, done_j, rdy_v, en_v, bits, nbits);
      chk("abort_nodone", done_j, 32'hFFFF_FFFF);
      #1;
      chk_reset("abort");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (frame_done1) cnt++;
      end
      chk("abort_quiet", cnt, 32'd0);

      run_frame(8'hD4, 8'h00, 8'h00, 1, 0, -1, done_j, rdy_v, en_v, bits, nbits);
      chk("post_cycle", done_j + 1, 32'd10);
      chk("post_cnt",   match_count1, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Frame-level controller for the serial Moore sequence detector (pattern 110101, overlapping). It accepts parallel bytes on a valid/ready stream and serializes each frame MSB-first onto the detector's bit input. It gates and clears the detector between frames, counts detector hits per frame, and reports a saturating count with a one-cycle done pulse. It sits between the byte-stream source and the detector instance.

## Interface
- DATA_W, 8, bits per input beat, shifted MSB first
- CNT_W, 8, width of per-frame match counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  controller can accept a beat this cycle
- s_data  in  DATA_W  input beat
- s_last  in  1  beat is last of frame
- det_x  out  1  serial bit to detector
- det_en  out  1  detector advances state only when 1
- det_clr  out  1  synchronous clear to detector (back to initial state)
- det_y  in  1  detector Moore output
- frame_done  out  1  one-cycle pulse, frame result valid
- match_count  out  CNT_W  matches in last/current frame, saturating
- match_ovf  out  1  sticky, count saturated in this frame

## Operation
- States:
  - IDLE (no frame open)
  - SHIFT (bits to detector)
  - WAIT (mid-frame, starved)
  - DRAIN (collect last hit)
  - DONE
- IDLE: s_ready=1, det_clr=1, det_en=0. On accept (s_valid&&s_ready): shreg<=s_data, bit_idx<=DATA_W-1, last_q<=s_last, match_count<=0, match_ovf<=0 -> SHIFT.
- SHIFT: det_en=1, det_x=shreg[DATA_W-1]; shreg shifts left, bit_idx decrements each cycle. s_ready=1 only when bit_idx==0 && !last_q. At bit_idx==0:
  - last_q -> DRAIN
  - else accept -> reload, stay SHIFT (zero bubble)
  - else -> WAIT
- WAIT: det_en=0, det_clr=0, s_ready=1. Accept -> reload, SHIFT. Detector state held across arbitrary stalls.
- DRAIN: det_en=0, s_ready=0, one cycle -> DONE.
- DONE: frame_done=1, det_clr=1, s_ready=0 -> IDLE.
- Hit counting: en_q<=det_en each cycle. Increment when en_q&&det_y. A held Moore output is never double counted.
- Counter saturates at 2^CNT_W-1. An increment attempted at max sets match_ovf. match_count/match_ovf hold from DONE until the next frame's first accept.
- det_x=0 whenever det_en=0.

## Timing
- Reset values:
  - state=IDLE, s_ready=1, det_x=0, det_en=0, det_clr=1
  - frame_done=0, match_count=0, match_ovf=0, en_q=0
- Reset asserted mid-frame: immediate return to reset values. The partial frame is dropped and no frame_done is issued.
- First bit appears on det_x in the cycle after the accepting edge.
- Detector latency is 1 cycle: the hit for bit k is sampled in the following cycle via en_q.
- N-beat frame, no stalls: frame_done is high in cycle N·DATA_W+2 after the first accepting edge. Each WAIT cycle adds 1.
- s_ready is combinational from state/bit_idx only, with no path from s_valid.
- s_last on a 1-beat frame is legal: DATA_W SHIFT cycles, then DRAIN, then DONE.
- s_data/s_last are ignored when not accepted.

## Structure
- Shared package/header seq_det_ctrl_pkg holds:
  - state encodings (IDLE, SHIFT, WAIT, DRAIN, DONE, 3-bit binary)
  - default DATA_W/CNT_W
- One sub-module: sat_counter (CNT_W param; clr, inc; outputs count, ovf).
- The detector is instantiated alongside the controller by the parent, not inside it.
- The bench pairs the controller with the real detector and with a bit-level reference model of the overlapping 110101 match.

## Test plan
- Reset then idle: all outputs at reset values; det_clr=1, s_ready=1 for 20 cycles; match_count=0.
- Single beat 0xD4, s_last=1 -> det_x shows 1,1,0,1,0,1,0,0 on consecutive cycles; frame_done at cycle 10; match_count=1, match_ovf=0.
- Two beats 0xD6,0xA0 back-to-back, last on 2nd -> overlapping hits give match_count=2. frame_done at cycle 18. s_ready high only in the bit_idx==0 cycle of beat 1.
- Same frame with s_valid low 3 cycles between beats -> det_en=0 during WAIT. match_count=2 (no spurious hits). frame_done at cycle 21.
- Beats 0xD6,0xB5,0xAD -> match_count=4 with default CNT_W. With CNT_W=2 -> match_count=3, match_ovf=1.
- Reset asserted in SHIFT of beat 2, then 0xD4 frame -> no frame_done for the aborted frame. New frame reports match_count=1.
